// File: rtl/equation_pkg.sv
`default_nettype none
// ============================================================================
// Module      : equation_pkg
// Description : Shared widths and pipeline depth for the equation datapath.
//               IN_W    - operand width
//               OUT_W   - result / partial-sum width (results wrap mod 2^OUT_W)
//               LATENCY - rising edges from operand sampling to E
// Revision    : 1.0 - initial release
// ============================================================================
package equation_pkg;

  localparam int IN_W    = 8;
  localparam int OUT_W   = 16;
  localparam int LATENCY = 4;

  // Operand sum needs two guard bits so that three IN_W operands never overflow.
  localparam int SUM_W   = IN_W + 2;

endpackage
`default_nettype wire

// File: rtl/equation_mac.sv
`default_nettype none
// ============================================================================
// Module      : equation_mac
// Description : Registered multiply-accumulate stage.
//               out <= acc_in + x*y  (mod 2^OUT_W), async active-high reset.
// Ports       : clk    - rising-edge clock
//               rst    - asynchronous active-high reset, clears out
//               acc_in - partial sum from the previous stage
//               x, y   - unsigned operands
//               out    - registered partial sum
// Revision    : 1.0 - initial release
// ============================================================================
module equation_mac
  import equation_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [OUT_W-1:0] acc_in,
  input  logic [IN_W-1:0]  x,
  input  logic [IN_W-1:0]  y,
  output logic [OUT_W-1:0] out
);

  logic [OUT_W-1:0] prod;

  // Operands are zero-extended first so the 8x8 product is exact in 16 bits.
  assign prod = OUT_W'(x) * OUT_W'(y);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out <= '0;
    end else begin
      out <= acc_in + prod;
    end
  end

endmodule
`default_nettype wire

// File: rtl/equation.sv
`default_nettype none
// ============================================================================
// Module      : equation
// Description : Four-stage pipeline computing
//               E = A*B + B*C + A*C + A + B + C  (mod 2^16)
//               One operand set accepted per cycle, result after 4 edges.
// Ports       : clk      - rising-edge clock
//               rst      - asynchronous active-high reset, clears all state
//               A, B, C  - 8-bit unsigned operands
//               s1       - stage-1 register, A*B
//               s2       - stage-2 register, A*B + B*C
//               s3       - stage-3 register, A*B + B*C + A*C
//               E        - final result
// Revision    : 1.0 - initial release
// ============================================================================
module equation
  import equation_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  A,
  input  logic [IN_W-1:0]  B,
  input  logic [IN_W-1:0]  C,
  output logic [OUT_W-1:0] s1,
  output logic [OUT_W-1:0] s2,
  output logic [OUT_W-1:0] s3,
  output logic [OUT_W-1:0] E
);

  // Operand copies: index k holds the operands that entered k edges ago,
  // so each stage sees the operands belonging to its own partial sum.
  logic [IN_W-1:0] a_dly [1:LATENCY-1];
  logic [IN_W-1:0] b_dly [1:LATENCY-1];
  logic [IN_W-1:0] c_dly [1:LATENCY-1];

  logic [SUM_W-1:0] opnd_sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_dly[1] <= '0;
      b_dly[1] <= '0;
      c_dly[1] <= '0;
    end else begin
      a_dly[1] <= A;
      b_dly[1] <= B;
      c_dly[1] <= C;
    end
  end

  for (genvar k = 2; k < LATENCY; k++) begin : g_dly
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        a_dly[k] <= '0;
        b_dly[k] <= '0;
        c_dly[k] <= '0;
      end else begin
        a_dly[k] <= a_dly[k-1];
        b_dly[k] <= b_dly[k-1];
        c_dly[k] <= c_dly[k-1];
      end
    end
  end

  // Stage 1: A*B, nothing to accumulate yet.
  equation_mac u_stage1 (
    .clk    (clk),
    .rst    (rst),
    .acc_in ('0),
    .x      (A),
    .y      (B),
    .out    (s1)
  );

  // Stage 2: add B*C using the operands that produced s1.
  equation_mac u_stage2 (
    .clk    (clk),
    .rst    (rst),
    .acc_in (s1),
    .x      (b_dly[1]),
    .y      (c_dly[1]),
    .out    (s2)
  );

  // Stage 3: add A*C using the operands that produced s2.
  equation_mac u_stage3 (
    .clk    (clk),
    .rst    (rst),
    .acc_in (s2),
    .x      (a_dly[2]),
    .y      (c_dly[2]),
    .out    (s3)
  );

  // Stage 4: add the linear terms; sum is widened before adding to avoid loss.
  assign opnd_sum = SUM_W'(a_dly[LATENCY-1]) + SUM_W'(b_dly[LATENCY-1])
                  + SUM_W'(c_dly[LATENCY-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      E <= '0;
    end else begin
      E <= s3 + OUT_W'(opnd_sum);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_equation.sv
`default_nettype none
// ============================================================================
// Module      : tb_equation
// Description : Self-checking bench for equation. Each driven operand set
//               pushes its expected E onto a scoreboard queue tagged with the
//               cycle it is due; the result is popped and compared on the
//               falling edge of that cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_equation;

  logic        clk;
  logic        rst;
  logic [7:0]  A, B, C;
  logic [15:0] s1, s2, s3, E;

  equation dut (
    .clk (clk),
    .rst (rst),
    .A   (A),
    .B   (B),
    .C   (C),
    .s1  (s1),
    .s2  (s2),
    .s3  (s3),
    .E   (E)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] e;
    int          due;
  } sb_item_t;

  sb_item_t sb_q[$];
  int       cyc    = 0;
  int       n_vec  = 0;
  int       n_miss = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] e_model(input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] c);
    int r;
    r = int'(a) * int'(b) + int'(b) * int'(c) + int'(a) * int'(c)
      + int'(a) + int'(b) + int'(c);
    return r[15:0];
  endfunction

  // Called at a falling edge: apply operands, schedule the expected result,
  // then advance to the next falling edge (past the sampling edge).
  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    A = a;
    B = b;
    C = c;
    sb_q.push_back('{e: e_model(a, b, c), due: cyc + 4});
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst && sb_q.size() != 0 && sb_q[0].due == cyc) begin
      chk("E_sb", E, sb_q[0].e);
      void'(sb_q.pop_front());
    end
  end

  initial begin
    rst = 1'b1;
    A   = 8'd77;
    B   = 8'd200;
    C   = 8'd13;
    #1;
    // Reset acts immediately, before any clock edge.
    chk("rst_s1", s1, 16'd0);
    chk("rst_s2", s2, 16'd0);
    chk("rst_s3", s3, 16'd0);
    chk("rst_E",  E,  16'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_E", E, 16'd0);
    @(negedge clk);
    rst = 1'b0;

    // Held operands: stage values appear after 1/2/3 edges, E after 4.
    drive(8'd21, 8'd52, 8'd90);
    chk("s1_held", s1, 16'd1092);
    chk("E_early1", E, 16'd0);
    drive(8'd21, 8'd52, 8'd90);
    chk("s2_held", s2, 16'd5772);
    chk("E_early2", E, 16'd0);
    drive(8'd21, 8'd52, 8'd90);
    chk("s3_held", s3, 16'd7662);
    chk("E_early3", E, 16'd0);
    drive(8'd21, 8'd52, 8'd90);
    chk("E_held", E, 16'd7825);

    // Small patterns and the all-ones wrap case.
    drive(8'd1, 8'd1, 8'd1);
    drive(8'd0, 8'd0, 8'd0);
    drive(8'd2, 8'd1, 8'd1);
    drive(8'd255, 8'd255, 8'd255);
    drive(8'd0, 8'd255, 8'd0);
    drive(8'd255, 8'd0, 8'd255);
    repeat (3) drive(8'd0, 8'd0, 8'd0);
    chk("E_wrap_const", e_model(8'd255, 8'd255, 8'd255), 16'd64768);

    // Back-to-back random operands.
    for (int i = 0; i < 120; i++) begin
      drive(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
            8'($urandom_range(0, 255)));
    end

    // Mid-stream asynchronous reset, asserted away from any edge.
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("mid_rst_s1", s1, 16'd0);
    chk("mid_rst_s2", s2, 16'd0);
    chk("mid_rst_s3", s3, 16'd0);
    chk("mid_rst_E",  E,  16'd0);
    sb_q.delete();
    @(posedge clk);
    #1;
    chk("mid_rst_hold_E", E, 16'd0);
    @(negedge clk);
    rst = 1'b0;

    // First post-reset operand set must come through cleanly.
    drive(8'd33, 8'd44, 8'd55);
    for (int i = 0; i < 20; i++) begin
      drive(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
            8'($urandom_range(0, 255)));
    end

    // Drain the scoreboard with a bounded wait.
    A = 8'd0;
    B = 8'd0;
    C = 8'd0;
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      chk("drain_timeout", 16'(sb_q.size()), 16'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/equation.md
EQUATION -- requirements
Module: equation

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset; ports: clk, rst.
REQ-002 SHALL expose: clk  input  1  rising-edge clock for all state.
REQ-003 SHALL expose: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL expose: A  input  8  unsigned operand.
REQ-005 SHALL expose: B  input  8  unsigned operand.
REQ-006 SHALL expose: C  input  8  unsigned operand.
REQ-007 SHALL expose: s1  output  16  stage-1 register, A*B.
REQ-008 SHALL expose: s2  output  16  stage-2 register, partial sum.
REQ-009 SHALL expose: s3  output  16  stage-3 register, partial sum.
REQ-010 SHALL expose: E  output  16  final result, E = A*B + B*C + A*C + A + B + C mod 2^16.
REQ-011 SHALL have no parameters; widths IN_W=8, OUT_W=16, LATENCY=4 are fixed constants.

Function
REQ-012 SHALL sample A, B, C on every rising clk edge; no enable, no handshake; one new operand set accepted per cycle.
REQ-013 SHALL compute stage 1 at edge n: s1 = A*B (exact 16-bit product); register copies of A, B, C travel alongside.
REQ-014 SHALL compute stage 2 at edge n+1: s2 = s1 + B_d1*C_d1, mod 2^16.
REQ-015 SHALL compute stage 3 at edge n+2: s3 = s2 + A_d2*C_d2, mod 2^16.
REQ-016 SHALL compute stage 4 at edge n+3: E = s3 + (A_d3 + B_d3 + C_d3), mod 2^16; operand sum at least 10 bits wide, zero-extended.
REQ-017 SHALL give latency exactly 4 rising edges from operand sampling to E; s1/s2/s3 valid after 1/2/3 edges.
REQ-018 SHALL treat all arithmetic as unsigned; overflow wraps silently; no saturation, no flags.
REQ-019 SHALL keep each stage's delayed operands aligned with that stage's partial sum, so results from back-to-back inputs never mix.
REQ-020 SHALL drive all outputs directly from registers; no combinational path from inputs to outputs.

Reset
REQ-021 SHALL clear all pipeline registers, including the delayed operand copies, to 0 immediately on rst=1, independent of clk.
REQ-022 SHALL hold s1=s2=s3=E=0 while rst=1.
REQ-023 SHALL, after rst falls, let the first sampled set reach E 4 edges later; outputs before then stay 0, which matches an all-zero input stream.
REQ-024 SHALL discard all in-flight data when reset is asserted mid-operation; there is no partial recovery.

Structure
REQ-025 SHALL place IN_W, OUT_W and LATENCY in shared package equation_pkg.
REQ-026 SHALL use one sub-module, equation_mac: registered out = acc_in + x*y mod 2^16, with async reset; instantiate it for stages 2 and 3, with stage 1 as acc_in=0.
REQ-027 SHALL keep stage-4 adder and operand delay registers in the top module.

Verification
REQ-028 SHALL cover: rst=1 with arbitrary inputs -> s1=s2=s3=E=0 at once, no clock edge needed.
REQ-029 SHALL cover: A=21,B=52,C=90 held -> s1=1092, s2=5772, s3=7662, E=7825 after 1/2/3/4 edges.
REQ-030 SHALL cover: A=B=C=1 -> E=6; A=B=C=0 -> E=0; A=2,B=1,C=1 -> E=9; each appears 4 edges after sampling.
REQ-031 SHALL cover: A=B=C=255 -> E=64768, showing mod-2^16 wrap.
REQ-032 SHALL cover: a new random set on every cycle for 100+ cycles -> E equals a reference model delayed 4 cycles, with no cross-contamination.
REQ-033 SHALL cover: rst pulsed mid-stream -> all outputs 0 at once; the first post-reset E matches the operands sampled at the first edge after release.
